// File: rtl/msk_frame_sync.sv
// MSK frame synchroniser: correlates the bit stream against a sync word
// (either polarity), then unpacks a length byte and N payload bytes.
module msk_frame_sync #(
    parameter logic [31:0] SYNC_WORD = 32'h1ACF_FC1D,
    parameter int unsigned MAX_ERR   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_i,
    input  logic        data_valid_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic [7:0]  len_o,
    output logic        locked_o,
    output logic        inverted_o,
    output logic [15:0] frame_cnt_o
);

    typedef enum logic [1:0] {
        SEARCH,
        LEN,
        PAYLOAD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sr_q, sr_d, sr_nx;
    logic [5:0]  fill_q, fill_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shf_q, shf_d, shf_nx, byte_nx;
    logic [7:0]  rem_q, rem_d;
    logic        first_q, first_d;
    logic        inv_q, inv_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  len_q, len_d;
    logic        bv_q, bv_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic [15:0] fcnt_q, fcnt_d;

    function automatic int unsigned popcnt(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) n = n + 32'(v[i]);
        return n;
    endfunction

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        bit_d   = bit_q;
        shf_d   = shf_q;
        rem_d   = rem_q;
        first_d = first_q;
        inv_d   = inv_q;
        byte_d  = byte_q;
        len_d   = len_q;
        fcnt_d  = fcnt_q;
        bv_d    = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        sr_nx   = {sr_q[30:0], data_i};
        shf_nx  = {shf_q[6:0], data_i};
        byte_nx = shf_nx ^ {8{inv_q}};
        if (data_valid_i) begin
            unique case (state_q)
                SEARCH: begin
                    sr_d   = sr_nx;
                    fill_d = (fill_q == 6'd32) ? fill_q : fill_q + 6'd1;
                    // correlation only once a full word has been seen
                    if (fill_d == 6'd32) begin
                        if (popcnt(sr_nx ^ SYNC_WORD) <= MAX_ERR) begin
                            state_d = LEN;
                            inv_d   = 1'b0;
                            bit_d   = 3'd0;
                        end else if (popcnt(~sr_nx ^ SYNC_WORD) <= MAX_ERR) begin
                            state_d = LEN;
                            inv_d   = 1'b1;
                            bit_d   = 3'd0;
                        end
                    end
                end
                LEN: begin
                    shf_d = shf_nx;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        len_d = byte_nx;
                        if (byte_nx == 8'd0) begin
                            state_d = SEARCH;
                            fill_d  = 6'd0;
                            fcnt_d  = fcnt_q + 16'd1;
                        end else begin
                            state_d = PAYLOAD;
                            rem_d   = byte_nx;
                            first_d = 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    shf_d = shf_nx;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        byte_d  = byte_nx;
                        bv_d    = 1'b1;
                        sof_d   = first_q;
                        eof_d   = (rem_q == 8'd1);
                        first_d = 1'b0;
                        rem_d   = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_d = SEARCH;
                            fill_d  = 6'd0;
                            fcnt_d  = fcnt_q + 16'd1;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= SEARCH;
            sr_q    <= '0;
            fill_q  <= '0;
            bit_q   <= '0;
            shf_q   <= '0;
            rem_q   <= '0;
            first_q <= 1'b0;
            inv_q   <= 1'b0;
            byte_q  <= '0;
            len_q   <= '0;
            bv_q    <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            bit_q   <= bit_d;
            shf_q   <= shf_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            inv_q   <= inv_d;
            byte_q  <= byte_d;
            len_q   <= len_d;
            bv_q    <= bv_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = bv_q;
    assign sof_o        = sof_q;
    assign eof_o        = eof_q;
    assign len_o        = len_q;
    assign locked_o     = (state_q != SEARCH);
    assign inverted_o   = inv_q;
    assign frame_cnt_o  = fcnt_q;

endmodule

// File: doc/msk_frame_sync.md
MSK_FRAME_SYNC -- requirements
Module: msk_frame_sync

Interface
REQ-001 The block SHALL have parameter SYNC_WORD, default 32'h1ACF_FC1D: sync pattern, MSB received first.
REQ-002 The block SHALL have parameter MAX_ERR, default 2: maximum Hamming distance accepted as a sync match, legal range 0..7.
REQ-003 The block SHALL have one clock and a synchronous active-low reset:
- clk  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
REQ-004 The block SHALL have these data ports:
- data_i  in  1  demodulated bit from the slicer
- data_valid_i  in  1  qualifies data_i; one bit per asserted cycle
- byte_o  out  8  payload byte, first-received bit in bit 7
- byte_valid_o  out  1  one-cycle strobe qualifying byte_o
- sof_o  out  1  high with byte_valid_o on the first payload byte
- eof_o  out  1  high with byte_valid_o on the last payload byte
- len_o  out  8  payload length of the current or last frame
- locked_o  out  1  high while in LEN or PAYLOAD
- inverted_o  out  1  polarity of the current or last sync match; 1 = inverted
- frame_cnt_o  out  16  count of completed frames, wraps 0xFFFF->0

Function
REQ-005 The frame format SHALL be: 32-bit sync, 8-bit length N (MSB first), then N payload bytes.
REQ-006 The FSM SHALL have states SEARCH, LEN and PAYLOAD, and SHALL enter SEARCH on reset.
REQ-007 The block SHALL ignore input and hold all state on cycles with data_valid_i=0.
REQ-008 In SEARCH, each valid bit SHALL shift into a 32-bit register, sr_next = {sr[30:0], data_i}.
REQ-009 In SEARCH, a fill counter SHALL be cleared on entry and saturate at 32; matching SHALL be enabled only on the valid cycle where the count reaches or is already at 32.
REQ-010 Match test (combinational on sr_next): if popcount(sr_next ^ SYNC_WORD) <= MAX_ERR, the FSM SHALL go to LEN at the next edge with inv=0.
REQ-011 If no normal match and popcount(~sr_next ^ SYNC_WORD) <= MAX_ERR, the FSM SHALL go to LEN with inv=1.
REQ-012 A normal match SHALL take precedence over an inverted match.
REQ-013 On entry to LEN, inverted_o SHALL update to inv, and the bit counter SHALL clear.
REQ-014 In LEN and PAYLOAD, bits SHALL assemble MSB-first; on the 8th valid bit the assembled byte SHALL be XORed with {8{inv}}.
REQ-015 In LEN, the completed byte SHALL load len_o and SHALL NOT produce byte_valid_o.
REQ-016 If the length byte is N=0, the block SHALL return to SEARCH, increment frame_cnt_o, and emit no bytes.
REQ-017 If the length byte is N>0, the block SHALL enter PAYLOAD with the remaining-byte counter set to N.
REQ-018 In PAYLOAD, each completed byte SHALL drive byte_o and a one-cycle byte_valid_o strobe in the cycle after the clock edge that samples its 8th bit (latency 1 cycle).
- sof_o SHALL be high on the first payload byte; eof_o SHALL be high on the byte where the remaining count equals 1.
- For N=1, sof_o and eof_o SHALL both be high on the same byte.
REQ-019 On the last payload byte the block SHALL return to SEARCH, clear the fill counter and increment frame_cnt_o in the same edge.
REQ-020 While locked, the block SHALL NOT perform sync matching; a sync pattern inside the payload SHALL be output as data.
REQ-021 Outputs byte_valid_o, sof_o and eof_o SHALL be registered pulses that are never high on two consecutive cycles.

Reset
REQ-022 With reset_n=0 sampled on a clk edge, the block SHALL enter SEARCH and clear the shift register, fill, bit and byte counters and inv.
REQ-023 Reset SHALL drive byte_o=0, byte_valid_o=0, sof_o=0, eof_o=0, len_o=0, locked_o=0, inverted_o=0 and frame_cnt_o=0 on the next cycle.
REQ-024 Reset asserted mid-frame SHALL abort the frame without asserting eof_o; 32 new valid bits are then required before a match.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- 1ACFFC1D, 03, A5 5A FF, bits on consecutive cycles -> bytes A5, 5A, FF; sof_o on A5; eof_o on FF; len_o=3; inverted_o=0; frame_cnt_o=1.
- Bitwise-inverted stream E530 03E2 FC A5 A5 00 -> bytes 5A, 5A, FF; inverted_o=1.
- Sync with 2 bit errors -> lock; with 3 bit errors -> no lock and no bytes output.
- Length 00, then 1ACFFC1D 01 7E -> first frame emits nothing with frame_cnt_o=1; second frame emits 7E with sof_o=eof_o=1 and frame_cnt_o=2.
- Payload containing 1ACFFC1D, and data_valid_i toggling 50% -> payload output verbatim with no relock; byte spacing follows valid bits.
- reset_n low for 1 cycle after the 2nd payload byte -> no eof_o, all outputs 0; the next full frame decodes correctly.
